// File: rtl/adder_arbiter.sv
// Two-requester round-robin front end for the shared 8-bit carry-select adder.
// One operation in flight; registered result and flags, one-cycle done strobe per owner.

module csa (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout,
    output logic       overflow
);
    logic [7:0] b_eff;
    logic [4:0] lower;
    logic [4:0] upper0;
    logic [4:0] upper1;
    logic [4:0] upper;

    // cin doubles as the subtract select: invert B and add one
    assign b_eff  = b ^ {8{cin}};
    assign lower  = {1'b0, a[3:0]} + {1'b0, b_eff[3:0]} + {4'b0000, cin};
    assign upper0 = {1'b0, a[7:4]} + {1'b0, b_eff[7:4]};
    assign upper1 = {1'b0, a[7:4]} + {1'b0, b_eff[7:4]} + 5'd1;
    assign upper  = lower[4] ? upper1 : upper0;

    assign s        = {upper[3:0], lower[3:0]};
    assign cout     = upper[4];
    assign overflow = (a[7] == b_eff[7]) && (s[7] != a[7]);
endmodule

// state | meaning
// IDLE  | waiting for a request; grant is live
// EXEC  | operands latched, adder output captured at end of cycle
// DONE  | result valid, done strobe to owner
module adder_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid0,
    input  logic       valid1,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
    input  logic       sub0,
    input  logic       sub1,
    output logic       ready0,
    output logic       ready1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] result,
    output logic       cout,
    output logic       overflow,
    output logic       busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       op_sub;
    logic       owner;
    logic       last;
    logic       grant0;
    logic       grant1;
    logic [7:0] csa_s;
    logic       csa_cout;
    logic       csa_ovf;

    csa u_csa (
        .a        (op_a),
        .b        (op_b),
        .cin      (op_sub),
        .s        (csa_s),
        .cout     (csa_cout),
        .overflow (csa_ovf)
    );

    // On contention the requester not served last wins
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            if (valid0 && valid1) begin
                grant0 = last;
                grant1 = !last;
            end else begin
                grant0 = valid0;
                grant1 = valid1;
            end
        end
    end

    assign ready0 = grant0;
    assign ready1 = grant1;
    assign busy   = (state != IDLE);
    assign done0  = (state == DONE) && !owner;
    assign done1  = (state == DONE) && owner;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_a     <= 8'h00;
            op_b     <= 8'h00;
            op_sub   <= 1'b0;
            owner    <= 1'b0;
            last     <= 1'b1;
            result   <= 8'h00;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        state  <= EXEC;
                        op_a   <= grant1 ? a1 : a0;
                        op_b   <= grant1 ? b1 : b0;
                        op_sub <= grant1 ? sub1 : sub0;
                        owner  <= grant1;
                        last   <= grant1;
                    end
                end
                EXEC: begin
                    state    <= DONE;
                    result   <= csa_s;
                    cout     <= csa_cout;
                    overflow <= csa_ovf;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
